// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: command FIFO in front of an external combinational ALU.
// Commands {a, b, sel} are buffered and the oldest one drives the ALU inputs.
// The ALU result and carry are captured into a registered output stage with a
// valid/ready handshake, and every captured result is counted.
module alu_op_sequencer #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_sel,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_select,
  input  logic [WIDTH-1:0] alu_output,
  input  logic             alu_carry_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_carry,
  output logic [1:0]       out_sel,
  output logic [CNT_W-1:0] op_count
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;

  // Command storage, one array per field.
  logic [WIDTH-1:0] mem_a_r   [DEPTH];
  logic [WIDTH-1:0] mem_b_r   [DEPTH];
  logic [1:0]       mem_sel_r [DEPTH];

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [AW-1:0]    wr_idx_s;
  logic [AW-1:0]    rd_idx_s;

  logic             full_s;
  logic             empty_s;
  logic             push_s;
  logic             issue_s;

  logic             out_valid_r;
  logic [WIDTH-1:0] out_result_r;
  logic             out_carry_r;
  logic [1:0]       out_sel_r;
  logic [CNT_W-1:0] op_count_r;

  assign wr_idx_s = wr_ptr_r[AW-1:0];
  assign rd_idx_s = rd_ptr_r[AW-1:0];

  assign empty_s  = (wr_ptr_r == rd_ptr_r);
  assign full_s   = (wr_ptr_r[PTR_W-1] != rd_ptr_r[PTR_W-1]) &&
                    (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);

  // Acceptance depends only on buffer state, never on the downstream consumer,
  // so a full buffer refuses a command even in a cycle where it also pops.
  assign in_ready = !full_s;
  assign push_s   = in_valid && !full_s;

  // A new result may be captured when the output stage is empty or being drained.
  assign issue_s  = !empty_s && (!out_valid_r || out_ready);

  assign out_valid  = out_valid_r;
  assign out_result = out_result_r;
  assign out_carry  = out_carry_r;
  assign out_sel    = out_sel_r;
  assign op_count   = op_count_r;

  // Present the head command to the ALU; park the ALU inputs at zero when idle.
  always_comb begin
    alu_a      = {WIDTH{1'b0}};
    alu_b      = {WIDTH{1'b0}};
    alu_select = 2'b00;
    if (!empty_s) begin
      alu_a      = mem_a_r[rd_idx_s];
      alu_b      = mem_b_r[rd_idx_s];
      alu_select = mem_sel_r[rd_idx_s];
    end else begin
      alu_a      = {WIDTH{1'b0}};
      alu_b      = {WIDTH{1'b0}};
      alu_select = 2'b00;
    end
  end

  // Command buffer contents: written at the tail on every accepted command.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_a_r[i]   <= {WIDTH{1'b0}};
        mem_b_r[i]   <= {WIDTH{1'b0}};
        mem_sel_r[i] <= 2'b00;
      end
    end else if (push_s) begin
      mem_a_r[wr_idx_s]   <= in_a;
      mem_b_r[wr_idx_s]   <= in_b;
      mem_sel_r[wr_idx_s] <= in_sel;
    end
  end

  // Pointer update: tail advances on push, head advances on issue.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (issue_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
    end
  end

  // Output stage: capture the ALU response on issue, drop valid once consumed.
  // The data fields are held after the consumer takes them.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_r  <= 1'b0;
      out_result_r <= {WIDTH{1'b0}};
      out_carry_r  <= 1'b0;
      out_sel_r    <= 2'b00;
    end else if (issue_s) begin
      out_valid_r  <= 1'b1;
      out_result_r <= alu_output;
      out_carry_r  <= alu_carry_out;
      out_sel_r    <= alu_select;
    end else if (out_valid_r && out_ready) begin
      out_valid_r  <= 1'b0;
    end
  end

  // Completed-operation counter; wraps naturally from all-ones to zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_count_r <= {CNT_W{1'b0}};
    end else if (issue_s) begin
      op_count_r <= op_count_r + CNT_W'(1);
    end
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Upstream/downstream wrapper stage for the combinational 4-bit ALU (sel 0=AND, 1=OR, 2=XOR, 3=ADD with carry out).
- Accepts operation commands {a, b, sel} over a valid/ready interface and buffers them in a small FIFO.
- Presents the FIFO head to the ALU input ports, then captures the ALU result and carry into a registered output with valid/ready handshake.
- Counts completed operations.
- The ALU stays instantiated outside this block. This block only drives its inputs and samples its outputs.

Parameters:
- DEPTH, 4, command FIFO entries (power of two, >=2).
- WIDTH, 4, operand/result width; must match the ALU.
- CNT_W, 8, width of the completed-operation counter.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  command present.
- in_ready  out  1  FIFO can accept a command.
- in_a  in  WIDTH  operand a.
- in_b  in  WIDTH  operand b.
- in_sel  in  2  opcode.
- alu_a  out  WIDTH  to ALU port a.
- alu_b  out  WIDTH  to ALU port b.
- alu_select  out  2  to ALU select.
- alu_output  in  WIDTH  ALU result (combinational from alu_a/alu_b/alu_select).
- alu_carry_out  in  1  ALU carry.
- out_valid  out  1  result register holds a result.
- out_ready  in  1  consumer accepts the result.
- out_result  out  WIDTH  registered result.
- out_carry  out  1  registered carry.
- out_sel  out  2  opcode that produced the result.
- op_count  out  CNT_W  number of results captured since reset.

Behaviour:
- Reset is synchronous and active-high: on a clk edge with reset=1, all state clears regardless of other inputs.
  - FIFO empty, rd/wr pointers 0.
  - out_valid=0, out_result=0, out_carry=0, out_sel=0, op_count=0.
  - in_ready=1 in the first cycle after reset deasserts.
- in_ready = !full. This is combinational from state only, with no dependency on out_ready.
- push = in_valid & in_ready. When push is true, {in_a, in_b, in_sel} is written at the tail on the edge.
- ALU drive:
  - While the FIFO is non-empty: alu_a / alu_b / alu_select = head entry, combinational from the registers.
  - While empty: all three = 0.
- issue = !empty & (!out_valid | out_ready).
- On an issue edge:
  - alu_output, alu_carry_out and the head sel are captured into out_result, out_carry and out_sel.
  - The head is popped, out_valid<=1, and op_count increments (wraps from all-ones to 0).
- When out_valid & out_ready and not issue: out_valid<=0. The out_result, out_carry and out_sel values are held (not cleared).
- Latency: a command pushed at edge N is at the head of an otherwise empty FIFO after N. Its result is captured at edge N+1, so out_valid=1 in cycle N+1..N+2. Minimum 1 cycle from acceptance to result.
- Throughput: 1 result/cycle while out_ready=1 and the FIFO is non-empty.
- Simultaneous push and pop:
  - Permitted when not full; occupancy is unchanged.
  - When full, in_ready=0, so there is no push even if a pop occurs that edge. There is no bypass.
- Backpressure: out_valid=1 & out_ready=0 gives no issue. The result register, head, ALU drive and op_count are all frozen.
- Empty: no issue. out_valid falls after the last handshake.
- Pointers are log2(DEPTH)+1 bits.
  - full = MSBs differ and the low bits are equal.
  - empty = pointers equal.
  - Pointers wrap naturally.
- Carry is captured as supplied by the ALU for every opcode. No masking.
- Reset mid-operation discards all buffered commands and any pending result. There is no output handshake in the reset cycle.

Test Plan:
1. Reset, then push {a=F, b=F, sel=0} with out_ready=1. Next cycle: alu_a=F, alu_b=F, alu_select=0. One cycle later: out_valid=1, out_result=F, out_carry=0, out_sel=0, op_count=1.
2. Back-to-back pushes {1,E,1}, {E,1,2}, {F,F,3} with out_ready=1. Results appear in consecutive cycles:
   - F/0/sel1
   - F/0/sel2
   - E/1/sel3
   - op_count=3 at the end.
3. Hold out_ready=0 and push 5 commands:
   - One command is captured into the result register.
   - in_ready drops to 0 once DEPTH=4 entries remain buffered.
   - out_result and op_count stay frozen.
   - Release out_ready: all 5 results drain in order, one per cycle.
4. FIFO full, in_valid=1, out_ready=1 in the same cycle: the pop occurs and the push does not. The next cycle has in_ready=1 and occupancy 3.
5. Assert reset while 3 commands are buffered and out_valid=1. Next cycle:
   - out_valid=0, op_count=0, in_ready=1.
   - alu_a=0, alu_b=0, alu_select=0.
   - No stale result emerges afterwards.
6. Issue 256 ADD {0,0,3} ops: op_count wraps to 0 after the 256th capture.
